// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch front end.
package fetch_pkg;

   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP              = 32'h0000_0000;
   localparam int unsigned PC_INC           = 4;
   localparam int unsigned PERF_W           = 32;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating fetch / bubble event counters, built only when FETCH_PERF_EN is defined.
`ifdef FETCH_PERF_EN
module fetch_perf_counters
   import fetch_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              fire,
   input  logic              bubble,
   output logic [PERF_W-1:0] perf_fetch_cnt,
   output logic [PERF_W-1:0] perf_bubble_cnt
);

   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (&v) ? v : v + PERF_W'(1);
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetch_cnt  <= '0;
         perf_bubble_cnt <= '0;
      end else begin
         if (fire)   perf_fetch_cnt  <= sat_inc(perf_fetch_cnt);
         if (bubble) perf_bubble_cnt <= sat_inc(perf_bubble_cnt);
      end
   end

endmodule
`endif

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, one-cycle-latency icache interface, redirect kill.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEF[ADDR_WIDTH-1:0]
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  icache_enable,
   output logic [ADDR_WIDTH-1:0] icache_addr,
   input  logic [DATA_WIDTH-1:0] icache_data,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic [ADDR_WIDTH-1:0] pc_plus4,
   output logic                  instr_valid
`ifdef FETCH_PERF_EN
   ,
   output logic [PERF_W-1:0]     perf_fetch_cnt,
   output logic [PERF_W-1:0]     perf_bubble_cnt
`endif
);

   localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(PC_INC);

   logic [ADDR_WIDTH-1:0] pc, pc_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_q_d;
   fetch_state_e          valid_q, valid_d;
   logic                  fire;

   assign fire = !stall && !redirect;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc      <= RESET_VECTOR;
         pc_q    <= '0;
         valid_q <= EMPTY;
      end else begin
         pc      <= pc_d;
         pc_q    <= pc_q_d;
         valid_q <= valid_d;
      end
   end

   // Redirect outranks stall and kills whatever read is in flight.
   always_comb begin
      pc_d    = pc;
      pc_q_d  = pc_q;
      valid_d = valid_q;
      if (redirect) begin
         pc_d    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
         valid_d = EMPTY;
      end else if (fire) begin
         pc_q_d  = pc;
         pc_d    = pc + INC;
         valid_d = FULL;
      end
   end

   assign icache_enable = fire;
   assign icache_addr   = {pc[ADDR_WIDTH-1:2], 2'b00};
   assign instr_valid   = (valid_q == FULL);
   assign instr         = instr_valid ? icache_data : NOP[DATA_WIDTH-1:0];
   assign instr_pc      = pc_q;
   assign pc_plus4      = pc_q + INC;

`ifdef FETCH_PERF_EN
   fetch_perf_counters u_perf (
      .clk             (clk),
      .reset           (reset),
      .fire            (fire),
      .bubble          (!instr_valid || stall),
      .perf_fetch_cnt  (perf_fetch_cnt),
      .perf_bubble_cnt (perf_bubble_cnt)
   );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/redirect traffic.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, redirect;
   logic [31:0] redirect_pc;
   logic        icache_enable;
   logic [31:0] icache_addr;
   logic [31:0] icache_data = 32'h0;
   logic [31:0] instr, instr_pc, pc_plus4;
   logic        instr_valid;

   logic        zero = 1'b0;
   logic [31:0] zero32 = 32'h0;
   logic        en2;
   logic [31:0] addr2, instr2, ipc2, pp4_2;
   logic [31:0] data2 = 32'h0;
   logic        vld2;

`ifdef FETCH_PERF_EN
   logic [31:0] pf_cnt, pb_cnt, pf_cnt2, pb_cnt2;
`endif

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .icache_enable(icache_enable), .icache_addr(icache_addr), .icache_data(icache_data),
      .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid)
`ifdef FETCH_PERF_EN
      , .perf_fetch_cnt(pf_cnt), .perf_bubble_cnt(pb_cnt)
`endif
   );

   fetch_stage #(.RESET_VECTOR(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .reset(reset), .stall(zero), .redirect(zero), .redirect_pc(zero32),
      .icache_enable(en2), .icache_addr(addr2), .icache_data(data2),
      .instr(instr2), .instr_pc(ipc2), .pc_plus4(pp4_2), .instr_valid(vld2)
`ifdef FETCH_PERF_EN
      , .perf_fetch_cnt(pf_cnt2), .perf_bubble_cnt(pb_cnt2)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h11;
         32'h4:   return 32'h22;
         32'h8:   return 32'h33;
         default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
      endcase
   endfunction

   // Synchronous instruction memory: data appears the cycle after an enabled read.
   always @(posedge clk) if (icache_enable) icache_data <= mem_word(icache_addr);
   always @(posedge clk) if (en2) data2 <= mem_word(addr2);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference: what decode should see, and the next address the front end will request.
   typedef struct {
      logic        vld;
      logic [31:0] pc;
      logic [31:0] data;
   } slot_t;

   slot_t       expect_out;
   logic [31:0] next_fetch;

   task automatic model_reset();
      next_fetch     = 32'h0;
      expect_out.vld  = 1'b0;
      expect_out.pc   = 32'h0;
      expect_out.data = 32'h0;
   endtask

   task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
      logic fire_exp;
      stall = st; redirect = rd; redirect_pc = rpc;
      fire_exp = !st && !rd;
      #1;
      check("icache_enable", {31'b0, icache_enable}, {31'b0, fire_exp});
      if (fire_exp) check("icache_addr", icache_addr, next_fetch);
      @(posedge clk);
      if (rd) begin
         next_fetch     = rpc & 32'hFFFF_FFFC;
         expect_out.vld = 1'b0;
      end else if (!st) begin
         expect_out = '{1'b1, next_fetch, mem_word(next_fetch)};
         next_fetch = next_fetch + 32'd4;
      end
      #1;
      check("instr_valid", {31'b0, instr_valid}, {31'b0, expect_out.vld});
      check("instr", instr, expect_out.vld ? expect_out.data : 32'h0);
      if (expect_out.vld) begin
         check("instr_pc", instr_pc, expect_out.pc);
         check("pc_plus4", pc_plus4, expect_out.pc + 32'd4);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_instr"},    instr, 32'h0);
      check({tag, "_valid"},    {31'b0, instr_valid}, 32'h0);
      check({tag, "_instr_pc"}, instr_pc, 32'h0);
      check({tag, "_pc_plus4"}, pc_plus4, 32'h4);
      check({tag, "_addr"},     icache_addr, 32'h0);
      check({tag, "_enable"},   {31'b0, icache_enable}, {31'b0, !stall});
   endtask

   initial begin
      logic        st, rd;
      logic [31:0] rpc;
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      model_reset();
      #2;
      check_reset_outputs("rst");
      check("rv_addr", addr2, 32'hFFFF_FFFC);
      @(negedge clk) reset = 1'b0;

      step(0, 0, 32'h0);
      check("seq0_instr", instr, 32'h11);
      check("seq0_pc", instr_pc, 32'h0);
      check("rv_instr_pc", ipc2, 32'hFFFF_FFFC);
      check("rv_pc_plus4", pp4_2, 32'h0);
      check("rv_valid", {31'b0, vld2}, 32'h1);
      check("rv_next_addr", addr2, 32'h0);
      step(0, 0, 32'h0);
      check("seq1_instr", instr, 32'h22);
      check("seq1_pc", instr_pc, 32'h4);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 32'h0);
         check("stall_instr", instr, 32'h22);
         check("stall_pc", instr_pc, 32'h4);
      end
      step(0, 0, 32'h0);
      check("post_stall_instr", instr, 32'h33);
      check("post_stall_pc", instr_pc, 32'h8);

      step(0, 1, 32'h43);
      check("redir_bubble", {31'b0, instr_valid}, 32'h0);
      step(0, 0, 32'h0);
      check("redir_pc", instr_pc, 32'h40);
      step(1, 1, 32'h80);
      check("redir_stall_bubble", {31'b0, instr_valid}, 32'h0);
      step(0, 0, 32'h0);
      check("redir_stall_pc", instr_pc, 32'h80);
      step(0, 1, 32'h100);
      step(0, 1, 32'h200);
      step(0, 0, 32'h0);
      check("b2b_redir_pc", instr_pc, 32'h200);

      for (int i = 0; i < 400; i++) begin
         st  = ($urandom % 4) == 0;
         rd  = ($urandom % 7) == 0;
         rpc = $urandom;
         if ($urandom % 4 == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
         step(st, rd, rpc);
      end

      @(negedge clk) reset = 1'b1;
      stall = 1'b0; redirect = 1'b0;
      model_reset();
      @(negedge clk) reset = 1'b0;
      for (int i = 0; i < 5; i++) step(0, 0, 32'h0);
`ifdef FETCH_PERF_EN
      check("perf_fetch_pre", pf_cnt, 32'd5);
      check("perf_bubble_pre", pb_cnt, 32'd1);
`endif
      #2 reset = 1'b1;
      #1;
      check_reset_outputs("midrst");
`ifdef FETCH_PERF_EN
      check("perf_fetch_post", pf_cnt, 32'd0);
      check("perf_bubble_post", pb_cnt, 32'd0);
`endif
      model_reset();
      @(negedge clk) reset = 1'b0;
      step(0, 0, 32'h0);
      check("after_rst_pc", instr_pc, 32'h0);
      check("after_rst_instr", instr, 32'h11);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the pipelined MIPS core. Owns the program counter, drives address and read-enable into the synchronous instruction cache, and presents the returned instruction (with its PC and PC+4) to the IF/ID boundary. Handles pipeline stalls, branch/jump redirects and the one-cycle cache read latency, killing wrong-path fetches.

## Interface
- ADDR_WIDTH, 32, PC / cache address width
- DATA_WIDTH, 32, instruction width
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall  in  1  downstream hold; freezes PC and presented instruction
- redirect  in  1  branch/jump taken; overrides stall
- redirect_pc  in  ADDR_WIDTH  redirect target; bits [1:0] ignored (forced 0)
- icache_enable  out  1  cache read enable
- icache_addr  out  ADDR_WIDTH  cache byte address (word-aligned)
- icache_data  in  DATA_WIDTH  cache read data, valid one cycle after enabled read
- instr  out  DATA_WIDTH  instruction to decode; 0 (NOP) when instr_valid=0
- instr_pc  out  ADDR_WIDTH  address of instr
- pc_plus4  out  ADDR_WIDTH  instr_pc + 4, modulo 2^ADDR_WIDTH
- instr_valid  out  1  instr is a real, correct-path instruction

## Operation
- Registers: pc (next address to fetch), pc_q (address whose data is on icache_data), valid_q.
- State machine on valid_q: EMPTY (0) = no valid data on cache output; FULL (1) = valid data present.
- icache_addr = {pc[ADDR_WIDTH-1:2], 2'b00}; icache_enable = !stall && !redirect.
- Fire (icache_enable=1): pc_q <= pc; pc <= pc + 4 (wraps to 0 past all-ones); valid_q <= 1 (EMPTY->FULL or FULL->FULL).
- Stall (redirect=0): pc, pc_q, valid_q hold; cache not enabled, so icache_data and instr stay stable.
- Redirect (any state, regardless of stall): pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}; valid_q <= 0 (->EMPTY); the fetch currently in flight is killed.
- instr = valid_q ? icache_data : 0; instr_pc = pc_q; pc_plus4 = pc_q + 4.
- Reset: pc = RESET_VECTOR, pc_q = 0, valid_q = 0; outputs: icache_addr = RESET_VECTOR, icache_enable = !stall, instr = 0, instr_pc = 0, pc_plus4 = 4, instr_valid = 0.
- Reset asserted mid-stream discards any in-flight fetch; the first fetch after release is RESET_VECTOR.

## Timing
- Fetch latency: address issued in cycle N, instruction with instr_valid=1 in cycle N+1.
- Steady state: one instruction per cycle, consecutive PCs.
- Redirect in cycle N: instr_valid=0 in N+1; redirect_pc issued in N+1; its instruction is valid in N+2 (one-bubble penalty).
- Stall asserted in cycle N: instr/instr_pc unchanged in N+1 for as long as stall holds; on release, the next sequential instruction appears one cycle later.
- Simultaneous stall and redirect: redirect wins.
- Back-to-back redirects: the last one wins; no instruction is valid until one cycle after redirect deasserts.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_fetch_cnt (32 b, +1 per fire) and perf_bubble_cnt (32 b, +1 per cycle with instr_valid=0 or stall=1). Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- FETCH_PERF_EN undefined: no counter ports or logic; behaviour is otherwise identical.

## Structure
- Shared package fetch_pkg: RESET_VECTOR default, NOP encoding (32'h0000_0000), EMPTY/FULL state constants, PC increment constant 4.
- One sub-module, fetch_perf_counters, instantiated only under FETCH_PERF_EN; inputs are fire and bubble strobes.

## Test plan
- Reset, stall=0 with cache holding 0x11,0x22,0x33 at 0x0,0x4,0x8 -> cycle 1 instr=0x11/pc 0x0, cycle 2 0x22/0x4, cycle 3 0x33/0x8, instr_valid=1 throughout.
- Stall for 3 cycles while instr=0x22 -> icache_enable=0; instr=0x22, instr_pc=0x4 held; after release the next valid instruction is 0x33 at 0x8.
- Redirect to 0x43 (→0x40) while streaming -> next cycle instr_valid=0, instr=0; following cycle instr_pc=0x40 and instr_valid=1.
- Redirect and stall asserted together to 0x80 -> redirect taken, one bubble, then instruction at 0x80 valid even though stall was high.
- RESET_VECTOR=32'hFFFF_FFFC -> first instr_pc=FFFF_FFFC with pc_plus4=0; the next fetch address is 0x0.
- Reset asserted mid-stream (plus, under FETCH_PERF_EN, 5 fetches and 1 bubble) -> all outputs reset immediately; counters read 0 after reset, and 5 and 1 before it.
